spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_master_if.sv | 42 ++++
 rtl/spi_clkgen.sv | 44 ++++
 rtl/spi_master.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the SPI blocks: the controller state encoding and
// the mode-0 clock polarity/phase constants.
// No ports; imported with "import spi_pkg::*;".
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spi_state_e;

  // Mode 0: sck idles low, data is captured on the rising sck edge.
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if
// Bundles the command, response and SPI pin signals of spi_master.
// Ports (signals):
//   cmd_valid/cmd_ready : command handshake
//   cmd_len/ss/div/tx   : transfer length, slave index, half-period divisor, data
//   rsp_valid/rsp_ready : response handshake, rsp_rx = received bits
//   sck/ss/mosi/miso    : SPI pins
// Modports: master (the controller) and slave (whoever drives commands and miso).
interface spi_master_if #(
  parameter int DATA_W = 64,
  parameter int SS_W   = 8,
  parameter int DIV_W  = 16
);

  localparam int LEN_W = $clog2(DATA_W) + 1;
  localparam int IDX_W = $clog2(SS_W);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [IDX_W-1:0]  cmd_ss;
  logic [DIV_W-1:0]  cmd_div;
  logic [DATA_W-1:0] cmd_tx;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rx;
  logic              sck;
  logic [SS_W-1:0]   ss;
  logic              mosi;
  logic              miso;

  modport master (
    input  cmd_valid, cmd_len, cmd_ss, cmd_div, cmd_tx, rsp_ready, miso,
    output cmd_ready, rsp_valid, rsp_rx, sck, ss, mosi
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_ss, cmd_div, cmd_tx, rsp_ready, miso,
    input  cmd_ready, rsp_valid, rsp_rx, sck, ss, mosi
  );

endinterface

// File: rtl/spi_clkgen.sv
// spi_clkgen
// Half-period timer for the SPI controller. Each half period lasts
// i_div+1 clocks; counting down to zero means the full divisor range
// (including all ones) never overflows.
// Ports:
//   clock, reset : system clock, async active-high reset
//   i_load       : load the counter with i_div (start of a transfer)
//   i_run        : count; reloads automatically on expiry
//   i_div        : half-period divisor
//   o_expire     : one-clock pulse on the last clock of each half period
module spi_clkgen #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_expire
);

  logic [DIV_W-1:0] r_cnt;

  // Down-counter: load starts a half period, expiry reloads for the next
  // one, and an idle timer parks at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_div;
    end else if (i_run) begin
      if (r_cnt == '0) begin
        r_cnt <= i_div;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_expire = i_run && (r_cnt == '0);

endmodule

// File: rtl/spi_master.sv
// spi_master
// Mode-0 SPI master: one command in, one response out, MSB first.
// Ports:
//   clock, reset : system clock, async active-high reset
//   bus          : spi_master_if.master
//     cmd_*      : command (len bits, slave index, divisor, tx data)
//     rsp_*      : response (received bits right-aligned, upper bits zero)
//     sck/ss/mosi/miso : SPI pins, outputs straight from flops
import spi_pkg::*;

module spi_master #(
  parameter int DATA_W = 64,
  parameter int SS_W   = 8,
  parameter int DIV_W  = 16
) (
  input logic          clock,
  input logic          reset,
  spi_master_if.master bus
);

  localparam int LEN_W = $clog2(DATA_W) + 1;
  localparam int IDX_W = $clog2(SS_W);

  spi_state_e        r_state;
  logic              r_armed;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_bitsLeft;
  logic [IDX_W-1:0]  r_ssIdx;
  logic [DIV_W-1:0]  r_div;
  logic [DATA_W-1:0] r_txShift;
  logic [DATA_W-1:0] r_rx;
  logic              r_sck;
  logic              r_mosi;
  logic [SS_W-1:0]   r_ss;
  logic              r_cmdReady;
  logic              r_rspValid;

  logic              w_load;
  logic              w_run;
  logic              w_expire;
  logic [LEN_W-1:0]  w_lenSat;
  logic [DATA_W-1:0] w_txAligned;
  logic [SS_W-1:0]   w_ssSel;

  // Oversized lengths clamp to the data width, and the tx word is shifted
  // so bit len-1 sits at the top; from then on mosi is always the MSB.
  always_comb begin
    w_lenSat = bus.cmd_len;
    if (bus.cmd_len > LEN_W'(DATA_W)) begin
      w_lenSat = LEN_W'(DATA_W);
    end
    w_txAligned = bus.cmd_tx << (LEN_W'(DATA_W) - w_lenSat);
  end

  // Active-low one-hot select; an index with no matching line leaves every
  // select high while the transfer still clocks normally.
  always_comb begin
    w_ssSel = '1;
    for (int i = 0; i < SS_W; i++) begin
      if (int'(r_ssIdx) == i) begin
        w_ssSel[i] = 1'b0;
      end
    end
  end

  // The first SETUP clock only drives ss/mosi and loads the timer, so the
  // setup half period proper starts one clock after accept.
  assign w_load = (r_state == SETUP) && !r_armed;
  assign w_run  = ((r_state == SETUP) && r_armed) || (r_state == SHIFT);

  spi_clkgen #(
    .DIV_W(DIV_W)
  ) u_clkgen (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_load),
    .i_run    (w_run),
    .i_div    (r_div),
    .o_expire (w_expire)
  );

  // Controller FSM. Every pin and handshake output is a flop updated here.
  // sck rises and miso is sampled on the same edge; sck falls shift mosi to
  // the next bit except after the final bit. A low half with no bits left
  // ends the transfer: selects release and the response appears together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_armed    <= 1'b0;
      r_len      <= '0;
      r_bitsLeft <= '0;
      r_ssIdx    <= '0;
      r_div      <= '0;
      r_txShift  <= '0;
      r_rx       <= '0;
      r_sck      <= CPOL;
      r_mosi     <= 1'b0;
      r_ss       <= '1;
      r_cmdReady <= 1'b1;
      r_rspValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_state    <= SETUP;
            r_cmdReady <= 1'b0;
            r_armed    <= 1'b0;
            r_len      <= w_lenSat;
            r_bitsLeft <= w_lenSat;
            r_ssIdx    <= bus.cmd_ss;
            r_div      <= bus.cmd_div;
            r_txShift  <= w_txAligned;
            r_rx       <= '0;
          end
        end
        SETUP: begin
          if (!r_armed) begin
            if (r_len == '0) begin
              r_state    <= DONE;
              r_rspValid <= 1'b1;
            end else begin
              r_armed <= 1'b1;
              r_ss    <= w_ssSel;
              r_mosi  <= r_txShift[DATA_W-1];
            end
          end else if (w_expire) begin
            r_sck   <= ~CPOL;
            r_rx    <= {r_rx[DATA_W-2:0], bus.miso};
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_expire) begin
            if (r_sck != CPOL) begin
              r_sck      <= CPOL;
              r_bitsLeft <= r_bitsLeft - 1'b1;
              if (r_bitsLeft != LEN_W'(1)) begin
                r_txShift <= r_txShift << 1;
                r_mosi    <= r_txShift[DATA_W-2];
              end
            end else if (r_bitsLeft == '0) begin
              r_ss       <= '1;
              r_mosi     <= 1'b0;
              r_state    <= DONE;
              r_rspValid <= 1'b1;
            end else begin
              r_sck <= ~CPOL;
              r_rx  <= {r_rx[DATA_W-2:0], bus.miso};
            end
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            r_rspValid <= 1'b0;
            r_cmdReady <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_cmdReady;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_rx    = r_rx;
  assign bus.sck       = r_sck;
  assign bus.ss        = r_ss;
  assign bus.mosi      = r_mosi;

endmodule
